// File: rtl/harmonic_sequencer.sv
// harmonic_sequencer: per-sample frame controller that steps harmonic indices through
// scaler, sample lookup and even/odd adders, then latches totals and triggers the DAC.
module harmonic_sequencer #(
    parameter int SAMPLE_INTERVAL = 1000,
    parameter int MAX_HARMONICS   = 100
) (
    input  logic       i_Clock,
    input  logic       reset_n,
    input  logic [7:0] i_Harmonic_Count,
    input  logic       i_Param_Valid,
    input  logic       i_Sample_Ready,
    input  logic       i_Freq_Too_High,
    input  logic [1:0] i_Scaler_Ready,
    input  logic       i_Overrun_Clear,
    output logic [7:0] o_Harmonic,
    output logic       o_Next_Sample,
    output logic [1:0] o_Scaler_Start,
    output logic [1:0] o_Adder_Start,
    output logic       o_Adder_Clear,
    output logic       o_Latch_Totals,
    output logic       o_DAC_Send,
    output logic       o_Overrun,
    output logic       o_Busy
);
    localparam int TW = $clog2(SAMPLE_INTERVAL);
    localparam logic [TW-1:0] TICK_AT = TW'(SAMPLE_INTERVAL - 1);
    localparam logic [7:0] H_MAX = 8'(MAX_HARMONICS - 1);

    typedef enum logic [2:0] {IDLE, SCALE, SCALE_WAIT, SAMPLE_WAIT, NEXT, DONE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    harmonic_q, harmonic_d;
    logic [7:0]    shadow_q, shadow_d;
    logic [7:0]    active_q, active_d;
    logic          result_valid_q, result_valid_d;
    logic          overrun_q, overrun_d;
    logic          next_sample_q, next_sample_d;
    logic          adder_clear_q, adder_clear_d;
    logic          dac_send_q, dac_send_d;
    logic          tick, sel, scaler_start, adder_start, latch_totals;

    always_comb begin
        tick           = timer_q == TICK_AT;
        sel            = harmonic_q[0];
        timer_d        = tick ? '0 : timer_q + 1'b1;
        shadow_d       = i_Param_Valid ? i_Harmonic_Count : shadow_q;
        overrun_d      = i_Overrun_Clear ? 1'b0 : overrun_q;
        state_d        = state_q;
        harmonic_d     = harmonic_q;
        active_d       = active_q;
        result_valid_d = result_valid_q;
        next_sample_d  = 1'b0;
        adder_clear_d  = 1'b0;
        dac_send_d     = 1'b0;
        scaler_start   = 1'b0;
        adder_start    = 1'b0;
        latch_totals   = 1'b0;
        case (state_q)
            IDLE: if (tick) begin
                adder_clear_d = 1'b1;
                next_sample_d = 1'b1;
                dac_send_d    = result_valid_q;
                harmonic_d    = 8'd0;
                active_d      = shadow_q > H_MAX ? H_MAX : shadow_q;
                state_d       = SCALE;
            end
            SCALE: begin
                scaler_start = !tick;
                state_d      = SCALE_WAIT;
            end
            SCALE_WAIT: state_d = i_Scaler_Ready[sel] ? SAMPLE_WAIT : SCALE_WAIT;
            SAMPLE_WAIT: if (i_Sample_Ready) begin
                adder_start = !tick;
                state_d     = NEXT;
            end
            NEXT: if (harmonic_q == active_q || i_Freq_Too_High) begin
                state_d = DONE;
            end else if (!tick) begin
                harmonic_d    = harmonic_q + 8'd1;
                next_sample_d = 1'b1;
                state_d       = SCALE;
            end
            DONE: begin
                latch_totals   = 1'b1;
                result_valid_d = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A tick while busy cuts the frame short; partial totals are latched in DONE.
        if (tick && state_q != IDLE) begin
            overrun_d = 1'b1;
            state_d   = state_q == DONE ? IDLE : DONE;
        end
    end

    always_ff @(posedge i_Clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            harmonic_q     <= 8'd0;
            shadow_q       <= 8'd0;
            active_q       <= 8'd0;
            result_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            next_sample_q  <= 1'b0;
            adder_clear_q  <= 1'b0;
            dac_send_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            harmonic_q     <= harmonic_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            result_valid_q <= result_valid_d;
            overrun_q      <= overrun_d;
            next_sample_q  <= next_sample_d;
            adder_clear_q  <= adder_clear_d;
            dac_send_q     <= dac_send_d;
        end
    end

    assign o_Harmonic     = harmonic_q;
    assign o_Next_Sample  = next_sample_q & !tick;
    assign o_Scaler_Start = {scaler_start & sel, scaler_start & !sel};
    assign o_Adder_Start  = {adder_start & sel, adder_start & !sel};
    assign o_Adder_Clear  = adder_clear_q;
    assign o_Latch_Totals = latch_totals;
    assign o_DAC_Send     = dac_send_q;
    assign o_Overrun      = overrun_q;
    assign o_Busy         = state_q != IDLE;
endmodule

// File: doc/harmonic_sequencer.md
HARMONIC_SEQUENCER -- requirements
Module: harmonic_sequencer

Interface
REQ-001 Parameter SAMPLE_INTERVAL, default 1000: clocks per output sample (48 MHz / 48 kHz).
REQ-002 Parameter MAX_HARMONICS, default 100: hard upper limit on harmonics per frame.
REQ-003 i_Clock  in  1  sole clock; all logic on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous, active-low.
REQ-005 i_Harmonic_Count  in  8  requested last harmonic index, from ADC control.
REQ-006 i_Param_Valid  in  1  one-cycle strobe; i_Harmonic_Count valid.
REQ-007 i_Sample_Ready  in  1  sample-position lookup result valid.
REQ-008 i_Freq_Too_High  in  1  current harmonic above Nyquist.
REQ-009 i_Scaler_Ready  in  2  scaler done, [0] even, [1] odd.
REQ-010 i_Overrun_Clear  in  1  clears o_Overrun.
REQ-011 o_Harmonic  out  8  harmonic index being computed.
REQ-012 o_Next_Sample  out  1  one-cycle strobe; start lookup for o_Harmonic.
REQ-013 o_Scaler_Start  out  2  one-cycle strobe to scaler selected by o_Harmonic[0].
REQ-014 o_Adder_Start  out  2  one-cycle strobe to adder selected by o_Harmonic[0].
REQ-015 o_Adder_Clear  out  1  one-cycle strobe; zero both accumulators.
REQ-016 o_Latch_Totals  out  1  one-cycle strobe; capture adder totals for the DAC.
REQ-017 o_DAC_Send  out  1  one-cycle strobe; start DAC transfer.
REQ-018 o_Overrun  out  1  sticky; frame did not finish within SAMPLE_INTERVAL.
REQ-019 o_Busy  out  1  high in any state except IDLE.

Function
REQ-020 The sample timer SHALL count 0..SAMPLE_INTERVAL-1, free-running, wrapping to 0; tick = (timer == SAMPLE_INTERVAL-1), asserted for one cycle every SAMPLE_INTERVAL clocks.
REQ-021 On i_Param_Valid, Count_Shadow SHALL capture i_Harmonic_Count; Active_Count SHALL load min(Count_Shadow, MAX_HARMONICS-1) only at frame start, so mid-frame updates never affect the current frame.
REQ-022 States SHALL be IDLE, SCALE, SCALE_WAIT, SAMPLE_WAIT, NEXT, DONE.
REQ-023 IDLE, on tick (frame start): o_Adder_Clear=1, o_Next_Sample=1, o_Harmonic<=0, load Active_Count; o_DAC_Send=1 only if Result_Valid; -> SCALE next cycle.
REQ-024 SCALE: o_Scaler_Start[o_Harmonic[0]]=1 for one cycle; -> SCALE_WAIT.
REQ-025 SCALE_WAIT: hold until i_Scaler_Ready[o_Harmonic[0]]=1; -> SAMPLE_WAIT.
REQ-026 SAMPLE_WAIT: hold until i_Sample_Ready=1; then o_Adder_Start[o_Harmonic[0]]=1 for one cycle; -> NEXT.
REQ-027 NEXT: if o_Harmonic == Active_Count or i_Freq_Too_High -> DONE; else o_Harmonic<=o_Harmonic+1, o_Next_Sample=1, -> SCALE.
REQ-028 DONE: o_Latch_Totals=1 for one cycle, Result_Valid<=1; -> IDLE.
REQ-029 A frame SHALL process Active_Count+1 harmonics, fewer if i_Freq_Too_High is seen in NEXT; the adder index SHALL equal the harmonic index LSB.
REQ-030 A tick in any state other than IDLE SHALL set o_Overrun, deassert all start strobes that cycle, and force DONE next cycle (partial totals latched; sent on the following tick).
REQ-031 o_Overrun SHALL clear on i_Overrun_Clear; a simultaneous set SHALL take priority.
REQ-032 No two of o_Scaler_Start, o_Adder_Start, o_Next_Sample SHALL target different harmonics in the same cycle; each strobe SHALL be exactly one cycle wide.
REQ-033 o_Harmonic SHALL never exceed MAX_HARMONICS-1 and SHALL not wrap.

Reset
REQ-034 While reset_n=0: state IDLE, timer 0, o_Harmonic 0, Count_Shadow 0, Active_Count 0, Result_Valid 0, all strobes 0, o_Overrun 0, o_Busy 0.
REQ-035 After reset release, the first tick SHALL start a frame without o_DAC_Send; reset asserted mid-frame SHALL abort it immediately with no strobe emitted.

Verification
REQ-036 Count=3, scaler/sample ready 2 cycles after request: tick -> Adder_Start pattern [0]=1,[1]=1,[0]=1,[1]=1 for H=0..3, one Latch_Totals, no DAC_Send on the first frame, DAC_Send on the second tick.
REQ-037 i_Harmonic_Count=200 with Param_Valid -> next frame processes exactly 100 harmonics (H 0..99).
REQ-038 i_Freq_Too_High=1 at H=5 with Count=50 -> DONE after H=5, 6 adder strobes total.
REQ-039 Sample_Ready withheld 1200 cycles at H=2 -> o_Overrun=1 at tick, Latch_Totals next cycle, DAC_Send at the following tick; Overrun_Clear -> 0.
REQ-040 Param_Valid with Count=10 mid-frame of Count=4 -> current frame ends at H=4, next frame ends at H=10.
REQ-041 reset_n low at H=7 -> outputs 0 asynchronously; after release, first tick -> no DAC_Send, H restarts at 0.
